// File: rtl/pipeline_hazard_scoreboard.sv
// Hazard and forwarding controller for the in-order pipeline.
// DEPTH slots track the destination tags of in-flight instructions from the
// stage after issue through write-back. Each cycle the controller resolves
// both issue-stage sources against the slots. It then either stalls issue or
// selects the stage that forwards each operand.
module pipeline_hazard_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int DEPTH     = 4,
  parameter int SW        = 3,
  parameter int FORWARD   = 1,
  parameter int RF_BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_uses_a,
  input  logic [REG_AW-1:0] issue_src_a,
  input  logic              issue_uses_b,
  input  logic [REG_AW-1:0] issue_src_b,
  input  logic              issue_writes,
  input  logic [REG_AW-1:0] issue_dest,
  input  logic [SW-1:0]     issue_ready_stage,
  input  logic              issue_kill,
  input  logic [DEPTH-1:0]  squash_mask,
  output logic              stall,
  output logic [SW-1:0]     fwd_sel_a,
  output logic [SW-1:0]     fwd_sel_b,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_dest,
  output logic [SW-1:0]     inflight_count
);

  localparam logic [SW-1:0] DEPTH_SW = SW'(DEPTH);

  // Slot state; slot i is pipeline stage i+1
  logic [DEPTH-1:0]  valid_reg, valid_next;
  logic [DEPTH-1:0]  writes_reg, writes_next;
  logic [REG_AW-1:0] dest_reg [DEPTH];
  logic [REG_AW-1:0] dest_next [DEPTH];
  logic [SW-1:0]     rdy_reg [DEPTH];
  logic [SW-1:0]     rdy_next [DEPTH];
  logic [SW-1:0]     count_reg, count_next;

  // Per-slot source matches and per-slot resolution if that slot wins
  logic [DEPTH-1:0]  match_a, match_b;
  logic [DEPTH-1:0]  slot_ok;
  logic [SW-1:0]     slot_sel [DEPTH];

  logic              hazard_a, hazard_b;
  logic [SW-1:0]     sel_a, sel_b;
  logic [SW-1:0]     issue_rdy;
  logic              accept;

  // Clamp the issue ready stage into 1..DEPTH
  always_comb begin
    issue_rdy = issue_ready_stage;
    if (issue_ready_stage == '0) begin
      issue_rdy = SW'(1);
    end else if (issue_ready_stage > DEPTH_SW) begin
      issue_rdy = DEPTH_SW;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      // A squashed slot is invisible to matching in the same cycle; r0 never matches
      assign match_a[gi] = issue_uses_a && (issue_src_a != '0) && valid_reg[gi] &&
                           writes_reg[gi] && (dest_reg[gi] == issue_src_a) && !squash_mask[gi];
      assign match_b[gi] = issue_uses_b && (issue_src_b != '0) && valid_reg[gi] &&
                           writes_reg[gi] && (dest_reg[gi] == issue_src_b) && !squash_mask[gi];

      if (RF_BYPASS != 0 && gi == DEPTH - 1) begin : g_bypass
        // Write-first register file covers the write-back slot
        assign slot_ok[gi]  = 1'b1;
        assign slot_sel[gi] = '0;
      end else begin : g_fwd
        // Forwardable once the producer's stage has reached its ready stage
        assign slot_ok[gi]  = (FORWARD != 0) && (rdy_reg[gi] <= SW'(gi + 1));
        assign slot_sel[gi] = SW'(gi + 1);
      end

      if (gi == 0) begin : g_load
        assign valid_next[gi]  = accept;
        assign writes_next[gi] = accept && issue_writes;
        assign dest_next[gi]   = accept ? issue_dest : '0;
        assign rdy_next[gi]    = accept ? issue_rdy : '0;
      end else begin : g_shift
        logic keep;
        assign keep            = valid_reg[gi-1] && !squash_mask[gi-1];
        assign valid_next[gi]  = keep;
        assign writes_next[gi] = keep && writes_reg[gi-1];
        assign dest_next[gi]   = keep ? dest_reg[gi-1] : '0;
        assign rdy_next[gi]    = keep ? rdy_reg[gi-1] : '0;
      end
    end
  endgenerate

  // Youngest matching slot wins: scan oldest to youngest, last hit overrides
  always_comb begin
    hazard_a = 1'b0;
    hazard_b = 1'b0;
    sel_a    = '0;
    sel_b    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (match_a[i]) begin
        hazard_a = !slot_ok[i];
        sel_a    = slot_ok[i] ? slot_sel[i] : '0;
      end
      if (match_b[i]) begin
        hazard_b = !slot_ok[i];
        sel_b    = slot_ok[i] ? slot_sel[i] : '0;
      end
    end
  end

  assign stall  = issue_valid && !issue_kill && (hazard_a || hazard_b);
  assign accept = issue_valid && !stall && !issue_kill;

  // Occupancy after this cycle's shift
  always_comb begin
    count_next = '0;
    for (int i = 0; i < DEPTH; i++) begin
      count_next = count_next + SW'(valid_next[i]);
    end
  end

  // Slot array advances every cycle; reset clears it immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_reg  <= '0;
      writes_reg <= '0;
      count_reg  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_reg[i] <= '0;
        rdy_reg[i]  <= '0;
      end
    end else begin
      valid_reg  <= valid_next;
      writes_reg <= writes_next;
      count_reg  <= count_next;
      for (int i = 0; i < DEPTH; i++) begin
        dest_reg[i] <= dest_next[i];
        rdy_reg[i]  <= rdy_next[i];
      end
    end
  end

  assign fwd_sel_a      = sel_a;
  assign fwd_sel_b      = sel_b;
  assign wb_valid       = valid_reg[DEPTH-1] && writes_reg[DEPTH-1] && !squash_mask[DEPTH-1];
  assign wb_dest        = dest_reg[DEPTH-1];
  assign inflight_count = count_reg;

endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// Directed bench for pipeline_hazard_scoreboard. The dut instance uses the
// default configuration with forwarding. The dut_nf instance has no forwarding
// and is driven with the same inputs.
module tb_pipeline_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       rst;
  logic       issue_valid, issue_uses_a, issue_uses_b, issue_writes, issue_kill;
  logic [4:0] issue_src_a, issue_src_b, issue_dest;
  logic [2:0] issue_ready_stage;
  logic [3:0] squash_mask;

  logic       stall, wb_valid;
  logic [2:0] fwd_sel_a, fwd_sel_b, inflight_count;
  logic [4:0] wb_dest;

  logic       nf_stall, nf_wb_valid;
  logic [2:0] nf_sel_a, nf_sel_b, nf_count;
  logic [4:0] nf_wb_dest;

  int tests_run = 0;
  int tests_failed = 0;
  int exp_chain_sel [4] = '{1, 2, 3, 0};
  int exp_nf_stall [4] = '{1, 1, 1, 0};

  always #5 clk = ~clk;

  pipeline_hazard_scoreboard dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_uses_a(issue_uses_a), .issue_src_a(issue_src_a),
    .issue_uses_b(issue_uses_b), .issue_src_b(issue_src_b),
    .issue_writes(issue_writes), .issue_dest(issue_dest),
    .issue_ready_stage(issue_ready_stage), .issue_kill(issue_kill),
    .squash_mask(squash_mask),
    .stall(stall), .fwd_sel_a(fwd_sel_a), .fwd_sel_b(fwd_sel_b),
    .wb_valid(wb_valid), .wb_dest(wb_dest), .inflight_count(inflight_count)
  );

  pipeline_hazard_scoreboard #(.FORWARD(0)) dut_nf (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_uses_a(issue_uses_a), .issue_src_a(issue_src_a),
    .issue_uses_b(issue_uses_b), .issue_src_b(issue_src_b),
    .issue_writes(issue_writes), .issue_dest(issue_dest),
    .issue_ready_stage(issue_ready_stage), .issue_kill(issue_kill),
    .squash_mask(squash_mask),
    .stall(nf_stall), .fwd_sel_a(nf_sel_a), .fwd_sel_b(nf_sel_b),
    .wb_valid(nf_wb_valid), .wb_dest(nf_wb_dest), .inflight_count(nf_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("[TB] ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 0; issue_uses_a = 0; issue_src_a = 0; issue_uses_b = 0;
    issue_src_b = 0; issue_writes = 0; issue_dest = 0; issue_ready_stage = 0;
    issue_kill = 0; squash_mask = 0;
  endtask

  task automatic drive(input logic v, input logic w, input logic [4:0] d, input logic [2:0] r,
                       input logic ua, input logic [4:0] sa, input logic ub, input logic [4:0] sb);
    issue_valid = v; issue_writes = w; issue_dest = d; issue_ready_stage = r;
    issue_uses_a = ua; issue_src_a = sa; issue_uses_b = ub; issue_src_b = sb;
    issue_kill = 0;
  endtask

  task automatic drain();
    idle();
    repeat (5) tick();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", inflight_count, 0);
    check("reset_wb_valid", wb_valid, 0);
    rst = 1'b1;

    // Three producers, the last a load of r3, then a stalled consumer; reset mid-cycle
    drive(1, 1, 1, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 2, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 3, 2, 0, 0, 0, 0); tick();
    check("pre_rst_count", inflight_count, 3);
    drive(1, 0, 0, 1, 0, 0, 1, 3);
    #1;
    check("pre_rst_stall", stall, 1);
    rst = 1'b0;
    #1;
    check("async_rst_count", inflight_count, 0);
    check("async_rst_stall", stall, 0);
    check("async_rst_wb_valid", wb_valid, 0);
    rst = 1'b1;
    #1;
    check("post_rst_stall", stall, 0);
    check("post_rst_sel_b", fwd_sel_b, 0);
    tick();
    check("post_rst_count", inflight_count, 1);
    drain();
    check("drained_count", inflight_count, 0);

    // ALU chain: r3 forwarded from stages 1,2,3, then bypassed at write-back
    drive(1, 1, 3, 1, 0, 0, 0, 0); tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 0, 1, 1, 3, 0, 0);
      #1;
      check($sformatf("chain%0d_stall", k + 1), stall, 0);
      check($sformatf("chain%0d_sel_a", k + 1), fwd_sel_a, exp_chain_sel[k]);
      if (k == 3) begin
        check("chain_wb_valid", wb_valid, 1);
        check("chain_wb_dest", wb_dest, 3);
        squash_mask = 4'b1000;
        #1;
        check("squash_wb_valid", wb_valid, 0);
        squash_mask = 4'b0000;
      end
      tick();
    end
    drain();

    // Load-use: one stall cycle, then forward from stage 2
    drive(1, 1, 5, 2, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 0, 0, 1, 5);
    #1;
    check("load_use_stall", stall, 1);
    tick();
    check("load_use_release_stall", stall, 0);
    check("load_use_sel_b", fwd_sel_b, 2);
    check("load_use_count", inflight_count, 1);
    tick();
    drain();

    // No forwarding: consumer of r7 waits until write-back
    drive(1, 1, 7, 1, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 1, 7, 0, 0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("nf_cycle%0d_stall", k), nf_stall, exp_nf_stall[k]);
      if (k == 3) begin
        check("nf_release_sel_a", nf_sel_a, 0);
        check("nf_release_wb_valid", nf_wb_valid, 1);
        check("nf_release_wb_dest", nf_wb_dest, 7);
      end
      tick();
    end
    drain();

    // Youngest wins: r4 in slot 0 and slot 2; consumer also writes r0 as a load
    drive(1, 1, 4, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 8, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 4, 1, 0, 0, 0, 0); tick();
    drive(1, 1, 0, 2, 1, 4, 0, 0);
    #1;
    check("young_stall", stall, 0);
    check("young_sel_a", fwd_sel_a, 1);
    tick();
    check("full_count", inflight_count, 4);
    drive(1, 0, 0, 1, 1, 4, 1, 0);
    #1;
    check("r0_stall", stall, 0);
    check("r0_sel_b", fwd_sel_b, 0);
    check("young2_sel_a", fwd_sel_a, 2);
    tick();
    drain();

    // Squash of slot 0 hides the load from the consumer and from slot 1
    drive(1, 1, 9, 2, 0, 0, 0, 0); tick();
    check("sq_pre_count", inflight_count, 1);
    drive(1, 0, 0, 1, 1, 9, 0, 0);
    squash_mask = 4'b0001;
    #1;
    check("sq_stall", stall, 0);
    check("sq_sel_a", fwd_sel_a, 0);
    tick();
    squash_mask = 4'b0000;
    drive(1, 0, 0, 0, 0, 0, 1, 9);
    #1;
    check("sq_slot1_sel_b", fwd_sel_b, 0);
    check("sq_post_count", inflight_count, 1);
    tick();
    drain();

    // Kill of a hazarded instruction: no stall, nothing loaded
    drive(1, 1, 10, 2, 0, 0, 0, 0); tick();
    drive(1, 0, 0, 1, 1, 10, 0, 0);
    issue_kill = 1'b1;
    #1;
    check("kill_stall", stall, 0);
    tick();
    idle();
    #1;
    check("kill_count", inflight_count, 1);
    drain();
    check("final_count", inflight_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
